// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch front end: owns the fetch PC, issues word reads to
// instruction memory over a req/ack handshake, and buffers returned words in a
// DEPTH-entry prefetch queue that feeds decode under valid/ready flow control.
// A redirect (taken branch/jump) flushes the queue and discards any response
// that is still in flight.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   mem_req, mem_addr     registered read request / word-aligned address
//   mem_ack, mem_rdata    memory completion strobe and read data
//   redirect_valid/_pc    restart fetch at redirect_pc (low 2 bits ignored)
//   inst_valid, inst,     queue head: valid flag, instruction word and the
//   inst_pc_plus_4        address of that instruction plus 4
//   inst_ready            decode accepts the head this cycle
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int                      ADDR_WIDTH = 32,
    parameter int                      DATA_WIDTH = 32,
    parameter int                      DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ack,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   inst_valid,
    output logic [DATA_WIDTH-1:0]  inst,
    output logic [ADDR_WIDTH-1:0]  inst_pc_plus_4,
    input  logic                   inst_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(32'd4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MSK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   fetch_pc_r, fetch_pc_s;
    logic [CNT_W-1:0]        count_r, count_s;
    logic [PTR_W-1:0]        rd_ptr_r, wr_ptr_r;
    logic                    mem_req_r, mem_req_s;
    logic [ADDR_WIDTH-1:0]   mem_addr_r, mem_addr_s;
    logic [DATA_WIDTH-1:0]   q_inst_r [DEPTH];
    logic [ADDR_WIDTH-1:0]   q_pc4_r  [DEPTH];
    logic                    push_s, pop_s, space_s;
    logic [ADDR_WIDTH-1:0]   pc_plus_4_s, redirect_pc_s;

    assign mem_req        = mem_req_r;
    assign mem_addr       = mem_addr_r;
    assign inst_valid     = (count_r != {CNT_W{1'b0}});
    assign inst           = q_inst_r[rd_ptr_r];
    assign inst_pc_plus_4 = q_pc4_r[rd_ptr_r];

    // Datapath decisions for this cycle: push/pop, next count and next fetch PC.
    always_comb begin
        pc_plus_4_s   = fetch_pc_r + WORD_STEP;
        redirect_pc_s = redirect_pc & ALIGN_MSK;
        // Only a live request (BUSY) may deliver data; stale acks in DROP are dropped.
        push_s = (state_r == BUSY) && mem_ack && !redirect_valid;
        pop_s  = inst_valid && inst_ready && !redirect_valid;
        if (redirect_valid) begin
            count_s    = {CNT_W{1'b0}};
            fetch_pc_s = redirect_pc_s;
        end else begin
            if (push_s && !pop_s) begin
                count_s = count_r + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_s = count_r - CNT_ONE;
            end else begin
                count_s = count_r;
            end
            fetch_pc_s = push_s ? pc_plus_4_s : fetch_pc_r;
        end
        // Every outstanding request owns a slot, so a push can never overflow.
        space_s = (count_s < DEPTH_C);
    end

    // Fetch FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!redirect_valid && space_s) begin
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (redirect_valid) begin
                    state_s = mem_ack ? IDLE : DROP;
                end else if (mem_ack) begin
                    state_s = space_s ? BUSY : IDLE;
                end else begin
                    state_s = BUSY;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    state_s = IDLE;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Fetch FSM outputs: request is high in BUSY/DROP; the address is held
    // during a request and otherwise follows the fetch PC, so a redirect target
    // is visible on mem_addr as soon as the FSM is back in IDLE.
    always_comb begin
        mem_req_s = (state_s != IDLE);
        if (state_s == IDLE) begin
            mem_addr_s = fetch_pc_s;
        end else if ((state_r == IDLE) || push_s) begin
            mem_addr_s = fetch_pc_s;
        end else begin
            mem_addr_s = mem_addr_r;
        end
    end

    // FSM state, fetch PC and registered memory-request outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            mem_req_r  <= 1'b0;
            mem_addr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            mem_req_r  <= mem_req_s;
            mem_addr_r <= mem_addr_s;
        end
    end

    // Queue occupancy and pointers; a redirect empties the queue in one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r  <= {CNT_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
        end else if (redirect_valid) begin
            count_r  <= {CNT_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
        end else begin
            count_r  <= count_s;
            rd_ptr_r <= pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            wr_ptr_r <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        end
    end

    // Queue storage: instruction word plus its PC+4 for decode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_inst_r[i] <= {DATA_WIDTH{1'b0}};
                q_pc4_r[i]  <= {ADDR_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            q_inst_r[wr_ptr_r] <= mem_rdata;
            q_pc4_r[wr_ptr_r]  <= pc_plus_4_s;
        end else begin
            q_inst_r[wr_ptr_r] <= q_inst_r[wr_ptr_r];
            q_pc4_r[wr_ptr_r]  <= q_pc4_r[wr_ptr_r];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clock;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc_plus_4;
    logic        inst_ready;

    logic        w_mem_req;
    logic [31:0] w_mem_addr;
    logic [31:0] w_rdata;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_pc4;

    int          checks;
    int          failures;
    int          popped;
    logic [31:0] salt;
    logic [31:0] exp_pc;   // address of the next instruction decode must receive

    // Instruction memory contents: a salted hash of the word address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt ^ {a[15:0], a[31:16]};
    endfunction

    assign mem_rdata = memfn(mem_addr);
    assign w_rdata   = memfn(w_mem_addr);

    fetch_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0100)) dut (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc_plus_4(inst_pc_plus_4),
        .inst_ready(inst_ready)
    );

    fetch_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clock(clock), .reset(reset),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ack(1'b1), .mem_rdata(w_rdata),
        .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
        .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc_plus_4(w_pc4),
        .inst_ready(1'b1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, update the stream
    // model, then check handshake stability and flush after the rising edge.
    task automatic step(input logic ack, input logic rdy, input logic redir, input logic [31:0] rpc);
        logic        pending;
        logic [31:0] paddr;
        mem_ack        = ack & mem_req;
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        pending        = mem_req && !mem_ack;
        paddr          = mem_addr;
        if (redir) begin
            exp_pc = rpc & 32'hFFFF_FFFC;
        end else if (inst_valid && rdy) begin
            chk("head_inst", inst, memfn(exp_pc));
            chk("head_pc4", inst_pc_plus_4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            popped++;
        end
        @(posedge clock);
        @(negedge clock);
        if (pending) begin
            chk("req_hold", mem_req, 1'b1);
            chk("addr_hold", mem_addr, paddr);
        end
        if (redir) chk("flush", inst_valid, 1'b0);
        chk("addr_align", mem_addr[1:0], 2'b00);
    endtask

    initial begin
        int nreq;
        int wc;
        int p0;
        checks = 0; failures = 0; popped = 0;
        salt = $urandom;
        exp_pc = 32'h0000_0100;
        reset = 1'b1; mem_ack = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;

        // Reset state
        @(negedge clock); @(negedge clock);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc4", inst_pc_plus_4, 32'h0);
        chk("rst_w_req", w_mem_req, 1'b0);
        reset = 1'b0;

        // Zero-wait streaming from 0x100, and the wrap-around instance
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (k <= 3) chk("addr_seq", mem_addr, 32'h100 + 32'(4 * (k - 1)));
            if (k >= 2) begin
                chk("pc4_seq", inst_pc_plus_4, 32'h104 + 32'(4 * (k - 2)));
                chk("valid_seq", inst_valid, 1'b1);
            end
            if (k == 1) chk("wrap_addr0", w_mem_addr, 32'hFFFF_FFFC);
            if (k == 2) begin
                chk("wrap_pc4", w_pc4, 32'h0);
                chk("wrap_inst", w_inst, memfn(32'hFFFF_FFFC));
                chk("wrap_addr1", w_mem_addr, 32'h0);
            end
        end

        // Redirect while BUSY with 0x10C outstanding, ack arrives later
        chk("pre_redir_addr", mem_addr, 32'h10C);
        step(1'b0, 1'b1, 1'b1, 32'h2003);
        chk("drop_addr", mem_addr, 32'h10C);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stale_req", mem_req, 1'b0);
        chk("stale_valid", inst_valid, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_req", mem_req, 1'b1);
        chk("redir_addr", mem_addr, 32'h2000);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_valid", inst_valid, 1'b1);
        chk("redir_pc4", inst_pc_plus_4, 32'h2004);

        // Same-cycle redirect, ack and pop with two entries queued
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("cnt2", dut.count_r, 3'd2);
        step(1'b1, 1'b1, 1'b1, 32'h3008);
        chk("same_cnt", dut.count_r, 3'd0);
        chk("same_req", mem_req, 1'b0);
        chk("same_addr", mem_addr, 32'h3008);

        // Backpressure: exactly DEPTH requests, then one more per pop
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_req) nreq++;
            step(1'b1, 1'b0, 1'b0, 32'h0);
        end
        chk("bp_nreq", 64'(nreq), 64'd4);
        chk("bp_req", mem_req, 1'b0);
        chk("bp_cnt", dut.count_r, 3'd4);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        nreq = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_req) nreq++;
            step(1'b1, 1'b0, 1'b0, 32'h0);
        end
        chk("bp_one_more", 64'(nreq), 64'd1);
        chk("bp_cnt2", dut.count_r, 3'd4);

        // Wait states: ack on the fourth cycle of every request
        step(1'b0, 1'b1, 1'b1, 32'h4000);
        p0 = popped;
        wc = 0;
        for (int i = 0; i < 24; i++) begin
            if (mem_req) wc++;
            step(wc == 4, 1'b1, 1'b0, 32'h0);
            if (wc == 4) wc = 0;
        end
        chk("wait_progress", 64'(popped - p0 >= 4), 64'd1);

        // Randomized traffic against the stream model
        p0 = popped;
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 39) == 0, $urandom);
        end
        chk("rand_progress", 64'(popped - p0 > 100), 64'd1);

        // Reset asserted mid-stream clears outputs immediately
        reset = 1'b1;
        #1;
        chk("midrst_req", mem_req, 1'b0);
        chk("midrst_addr", mem_addr, 32'h0);
        chk("midrst_valid", inst_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the pipelined MIPS core, replacing the bare PC register and IF/IF_ID path. It owns the fetch PC and issues word reads to instruction memory over a request/acknowledge handshake, so the memory may take any number of cycles. Returned words go into a DEPTH-entry prefetch queue that feeds decode under valid/ready flow control. A branch or jump redirect flushes the queue and discards any in-flight response.

## Interface
- ADDR_WIDTH, 32, width of PC and memory address
- DATA_WIDTH, 32, instruction word width
- DEPTH, 4, prefetch queue entries; power of two, at least 2
- RESET_PC, 0, fetch address after reset; word aligned

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- mem_req  out  1  read request to instruction memory, registered
- mem_addr  out  ADDR_WIDTH  request address, registered, low 2 bits always 0
- mem_ack  in  1  memory completes the current request this cycle
- mem_rdata  in  DATA_WIDTH  read data, valid only when mem_ack=1
- redirect_valid  in  1  branch/jump taken; restart fetch
- redirect_pc  in  ADDR_WIDTH  new fetch address; low 2 bits ignored (treated as 0)
- inst_valid  out  1  queue head valid (count != 0)
- inst  out  DATA_WIDTH  instruction at queue head
- inst_pc_plus_4  out  ADDR_WIDTH  address of the head instruction plus 4
- inst_ready  in  1  decode accepts the head; 0 = IF/ID stall

## Operation
- State: fetch_pc; queue storage, rd_ptr, wr_ptr, count (0..DEPTH); fetch FSM {IDLE, BUSY, DROP}.
- Space rule: a new request may be issued only when count (after this cycle's pop and push) < DEPTH. This reserves a slot for every outstanding request, so a push never finds the queue full.
- IDLE: if space is available and redirect_valid=0, go to BUSY with mem_req=1 and mem_addr=fetch_pc. Otherwise stay in IDLE with mem_req=0.
- BUSY: mem_req and mem_addr are held stable until mem_ack.
  - On mem_ack with no redirect: push {mem_rdata, fetch_pc+4} and set fetch_pc += 4.
  - After such a push, if space remains, stay in BUSY with mem_addr = new fetch_pc (back-to-back requests). Otherwise go to IDLE.
- Redirect in BUSY:
  - Without mem_ack: go to DROP; mem_req stays high at the old address until acked.
  - With mem_ack in the same cycle: discard the data and go to IDLE.
- DROP: on mem_ack, discard the data and go to IDLE. Another redirect_valid in DROP only updates fetch_pc.
- Any redirect_valid, in any state:
  - count, rd_ptr and wr_ptr are cleared.
  - fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - No push or pop happens that cycle; redirect has priority over both.
- Pop: when inst_valid && inst_ready and no redirect, advance rd_ptr and decrement count. A push and a pop in the same cycle leave count unchanged.
- Arithmetic: fetch_pc and pc+4 wrap modulo 2^ADDR_WIDTH. Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - fetch_pc = RESET_PC; FSM = IDLE; count = 0.
  - mem_req = 0; mem_addr = 0.
  - inst_valid = 0; inst = 0; inst_pc_plus_4 = 0.
- First mem_req rises in the first clock edge after reset deasserts, with mem_addr = RESET_PC.
- With zero-wait memory (mem_ack in the same cycle mem_req is seen): one word per cycle. The instruction appears as inst_valid in the cycle after its ack.
- inst and inst_pc_plus_4 are read from queue storage at rd_ptr and are stable while inst_valid=1 and inst_ready=0.
- Redirect to first new request: 1 cycle from IDLE or BUSY. From DROP, 1 cycle after the stale ack.
- Reset asserted mid-request: all state clears immediately and mem_req drops. The memory must abandon the transaction on reset.

## Test plan
- Reset with RESET_PC=0x100, mem_ack tied to 1, inst_ready=1:
  - mem_addr sequence 0x100, 0x104, 0x108 on consecutive cycles.
  - inst_pc_plus_4 sequence 0x104, 0x108, 0x10C, one per cycle.
- Backpressure: inst_ready=0, zero-wait memory:
  - Exactly DEPTH=4 requests are issued, then mem_req=0 with count=4.
  - Raise inst_ready for 1 cycle: one pop, then exactly one new request.
- Wait states: mem_ack delayed 3 cycles per request:
  - mem_req and mem_addr stay constant across the wait.
  - Each word is queued once, in order.
- Redirect while BUSY without ack: redirect_pc=0x2003 with request 0x10C outstanding:
  - Queue empties at once and mem_req holds 0x10C until ack.
  - The acked data never appears on inst.
  - The next request is to 0x2000 and the next inst_pc_plus_4 is 0x2004.
- Same-cycle redirect, ack and pop with count=2:
  - count becomes 0 and the acked word is dropped.
  - The next cycle shows mem_addr = redirect target.
- Wrap: RESET_PC=0xFFFFFFFC:
  - First inst_pc_plus_4 = 0x00000000.
  - Second mem_addr = 0x00000000.
